// File: rtl/wfq_ftime_table.sv
// wfq_ftime_table
//   Per-flow WFQ finish-time table. Each accepted update computes
//     F_new = sat(max(vtime, F_old) + (len << shift))
//   as a 3-stage read-modify-write (accept/read, compute, write) with
//   forwarding, so any spacing of updates to one flow matches strictly
//   sequential processing. After reset the table clears itself, one entry
//   per cycle. A second copy of the array, written in lockstep, serves the
//   scheduler read port.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   init_busy            high while the table is being cleared
//   upd_valid/upd_ready  update handshake (ready whenever clearing is done)
//   upd_flow/len/shift   flow index, packet length, weight shift
//   vtime                virtual time, sampled on acceptance
//   res_valid            one-cycle pulse, two cycles after acceptance
//   res_flow/res_ftime   flow index and the finish time written back
//   rd_en/rd_addr        scheduler read strobe and index
//   rd_data              finish time, one cycle after rd_en, held otherwise
module wfq_ftime_table #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11,
    parameter int SH_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_flow,
    input  logic [LEN_W-1:0]  upd_len,
    input  logic [SH_W-1:0]   upd_shift,
    input  logic [DATA_W-1:0] vtime,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_flow,
    output logic [DATA_W-1:0] res_ftime,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;
    // Widest possible increment is len shifted by the largest shift.
    localparam int INC_W = LEN_W + (1 << SH_W) - 1;
    // One spare bit above both operands so the sum can never wrap.
    localparam int SUM_W = ((INC_W > DATA_W) ? INC_W : DATA_W) + 1;
    localparam logic [DATA_W-1:0] MAX_FT = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] ftime_next(
        input logic [DATA_W-1:0] vt,
        input logic [DATA_W-1:0] f_old,
        input logic [LEN_W-1:0]  len,
        input logic [SH_W-1:0]   sh
    );
        logic [SUM_W-1:0] inc;
        logic [SUM_W-1:0] base;
        logic [SUM_W-1:0] sum;
        inc  = SUM_W'(len) << sh;
        base = SUM_W'((vt > f_old) ? vt : f_old);
        sum  = base + inc;
        if (sum > SUM_W'(MAX_FT)) begin
            ftime_next = MAX_FT;
        end else begin
            ftime_next = sum[DATA_W-1:0];
        end
    endfunction

    logic [DATA_W-1:0] upd_mem [DEPTH];
    logic [DATA_W-1:0] sch_mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              vld_p0_q, vld_p0_d;
    logic [ADDR_W-1:0] flow_p0_q, flow_p0_d;
    logic [LEN_W-1:0]  len_p0_q, len_p0_d;
    logic [SH_W-1:0]   shift_p0_q, shift_p0_d;
    logic [DATA_W-1:0] vtime_p0_q, vtime_p0_d;
    logic [DATA_W-1:0] rdat_p0_q;

    logic              vld_p1_q, vld_p1_d;
    logic [ADDR_W-1:0] flow_p1_q, flow_p1_d;
    logic [DATA_W-1:0] ftime_p1_q, ftime_p1_d;

    logic              vld_p2_q, vld_p2_d;
    logic [ADDR_W-1:0] flow_p2_q, flow_p2_d;
    logic [DATA_W-1:0] ftime_p2_q, ftime_p2_d;

    logic [DATA_W-1:0] sch_rd_q;
    logic              rd_zero_q, rd_zero_d;

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] f_old_p0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign upd_ready = (state_q == ST_RUN);
    assign accept    = upd_valid && upd_ready && !rst;

    // Shared write port: clearing during INIT, S2 write-back in RUN.
    // Nothing is written while rst is high so dropped updates leave no trace.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = flow_p1_q;
        wr_data = ftime_p1_q;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
            end else begin
                wr_en = vld_p1_q;
            end
        end
    end

    // ---- stage 0: capture request, array read in flight ----
    always_comb begin
        vld_p0_d   = accept;
        flow_p0_d  = upd_flow;
        len_p0_d   = upd_len;
        shift_p0_d = upd_shift;
        vtime_p0_d = vtime;
    end

    // ---- stage 1: resolve F_old, compute F_new ----
    // Gap 0: the previous update to this flow is in S2 right now.
    // Gap 1: it was written last cycle, the read saw the pre-write value.
    always_comb begin
        f_old_p0 = rdat_p0_q;
        if (vld_p1_q && (flow_p1_q == flow_p0_q)) begin
            f_old_p0 = ftime_p1_q;
        end else if (vld_p2_q && (flow_p2_q == flow_p0_q)) begin
            f_old_p0 = ftime_p2_q;
        end
    end

    always_comb begin
        vld_p1_d   = vld_p0_q;
        flow_p1_d  = flow_p1_q;
        ftime_p1_d = ftime_p1_q;
        if (vld_p0_q) begin
            flow_p1_d  = flow_p0_q;
            ftime_p1_d = ftime_next(vtime_p0_q, f_old_p0, len_p0_q, shift_p0_q);
        end
    end

    // ---- stage 2: write-back and result; remember the write for gap-1 ----
    assign res_valid = vld_p1_q && !rst;
    assign res_flow  = flow_p1_q;
    assign res_ftime = ftime_p1_q;

    always_comb begin
        vld_p2_d   = vld_p1_q;
        flow_p2_d  = flow_p1_q;
        ftime_p2_d = ftime_p1_q;
    end

    // Scheduler output is forced to zero when the read was issued during INIT.
    always_comb begin
        rd_zero_d = rd_zero_q;
        if (rd_en) begin
            rd_zero_d = (state_q == ST_INIT);
        end
    end

    assign rd_data = rd_zero_q ? '0 : sch_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            flow_p1_q  <= '0;
            ftime_p1_q <= '0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld_p0_q   <= vld_p0_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            flow_p1_q  <= flow_p1_d;
            ftime_p1_q <= ftime_p1_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    always_ff @(posedge clk) begin
        flow_p0_q  <= flow_p0_d;
        len_p0_q   <= len_p0_d;
        shift_p0_q <= shift_p0_d;
        vtime_p0_q <= vtime_p0_d;
        flow_p2_q  <= flow_p2_d;
        ftime_p2_q <= ftime_p2_d;
    end

    // Both copies are read-first: a read colliding with a write returns the
    // value held before that write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            upd_mem[wr_addr] <= wr_data;
            sch_mem[wr_addr] <= wr_data;
        end
        rdat_p0_q <= upd_mem[upd_flow];
        if (rd_en) begin
            sch_rd_q <= sch_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_wfq_ftime_table.sv
module tb_wfq_ftime_table;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_busy;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  upd_flow = '0;
    logic [10:0] upd_len = '0;
    logic [3:0]  upd_shift = '0;
    logic [15:0] vtime = '0;
    logic        res_valid;
    logic [3:0]  res_flow;
    logic [15:0] res_ftime;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    wfq_ftime_table #(.ADDR_W(AW), .DATA_W(16), .LEN_W(11), .SH_W(4)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_flow(upd_flow),
        .upd_len(upd_len), .upd_shift(upd_shift), .vtime(vtime),
        .res_valid(res_valid), .res_flow(res_flow), .res_ftime(res_ftime),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sequential WFQ update with saturation to 16 bits.
    function automatic int f_new(input int v, input int f, input int len, input int sh);
        longint s;
        s = longint'((v > f) ? v : f) + (longint'(len) << sh);
        return (s > 65535) ? 65535 : int'(s);
    endfunction

    typedef struct {
        int due;
        int flow;
        int ft;
    } res_t;

    res_t q[$];
    int   tbl[DEPTH];   // contents as the hardware array holds them
    int   lg[DEPTH];    // contents after every accepted update (sequential view)
    int   m_left = 0;
    int   m_rd = 0;
    bit   model_on = 0;

    initial forever begin
        bit exp_rv;
        int fn;
        @(negedge clk);
        if (model_on) begin
            exp_rv = !rst && (q.size() > 0) && (q[0].due == cyc);
            chk("init_busy", 32'(init_busy), 32'(m_left > 0));
            chk("upd_ready", 32'(upd_ready), 32'(m_left == 0));
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("res_flow", 32'(res_flow), q[0].flow);
                chk("res_ftime", 32'(res_ftime), q[0].ft);
            end
            chk("rd_data", 32'(rd_data), m_rd);
        end
        if (rst) begin
            m_left = DEPTH;
            q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] = 0;
                lg[i]  = 0;
            end
            m_rd     = 0;
            model_on = 1;
        end else if (model_on) begin
            if (rd_en) m_rd = (m_left > 0) ? 0 : tbl[rd_addr];
            if ((q.size() > 0) && (q[0].due == cyc)) begin
                tbl[q[0].flow] = q[0].ft;
                void'(q.pop_front());
            end
            if ((m_left == 0) && upd_valid) begin
                fn = f_new(int'(vtime), lg[upd_flow], int'(upd_len), int'(upd_shift));
                lg[upd_flow] = fn;
                q.push_back('{cyc + 2, int'(upd_flow), fn});
            end
            if (m_left > 0) m_left--;
        end
    end

    int got_flow[$];
    int got_ft[$];

    initial forever begin
        @(negedge clk);
        if (res_valid === 1'b1) begin
            got_flow.push_back(int'(res_flow));
            got_ft.push_back(int'(res_ftime));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_valid = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic put(input int f, input int v, input int l, input int s);
        upd_valid = 1'b1;
        upd_flow  = 4'(f);
        vtime     = 16'(v);
        upd_len   = 11'(l);
        upd_shift = 4'(s);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            tick();
            idle();
        end
    endtask

    task automatic clear_got();
        got_flow.delete();
        got_ft.delete();
    endtask

    task automatic chk_got(input string name, input int idx, input int exp);
        if (got_ft.size() > idx) chk(name, got_ft[idx], exp);
        else chk({name, "_missing"}, got_ft.size(), idx + 1);
    endtask

    // Called in the first INIT cycle; returns at the negedge of the first RUN cycle.
    task automatic init_count(input bit do_rd);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (do_rd && i == 4) chk("init_rd5", 32'(rd_data), 0);
            if (!init_busy) break;
            n++;
            tick();
            rd_en   = do_rd && (i == 2);
            rd_addr = 4'd5;
        end
        chk("init_len", n, DEPTH);
    endtask

    task automatic read_chk(input string name, input int a, input int exp);
        tick();
        rd_en   = 1'b1;
        rd_addr = 4'(a);
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        chk(name, 32'(rd_data), exp);
    endtask

    task automatic pair(input int f, input int gap);
        clear_got();
        tick();
        put(f, 10, 4, 0);
        repeat (gap) begin
            tick();
            idle();
        end
        tick();
        put(f, 10, 4, 0);
        drain(4);
        chk("pair_n", got_ft.size(), 2);
        chk_got("pair_first", 0, 14);
        chk_got("pair_second", 1, 18);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_init_busy", 32'(init_busy), 1);
        chk("rst_upd_ready", 32'(upd_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_flow", 32'(res_flow), 0);
        chk("rst_res_ftime", 32'(res_ftime), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        init_count(1'b1);

        // single update
        clear_got();
        tick();
        put(3, 100, 50, 1);
        drain(4);
        chk("single_n", got_ft.size(), 1);
        chk_got("single_ft", 0, 200);
        if (got_flow.size() > 0) chk("single_flow", got_flow[0], 3);
        read_chk("single_rd", 3, 200);

        // same flow at gap 0, 1, 2
        pair(7, 0);
        pair(10, 1);
        pair(11, 2);

        // max selection
        clear_got();
        tick();
        put(2, 490, 10, 0);
        drain(3);
        tick();
        put(2, 300, 10, 0);
        tick();
        put(2, 900, 10, 0);
        drain(4);
        chk_got("max_seed", 0, 500);
        chk_got("max_old", 1, 510);
        chk_got("max_vt", 2, 910);

        // saturation and the largest non-saturating sum
        clear_got();
        tick();
        put(4, 65530, 2047, 4);
        tick();
        put(5, 0, 2047, 15);
        tick();
        put(6, 65000, 534, 0);
        drain(4);
        chk_got("sat_sum", 0, 65535);
        chk_got("sat_inc", 1, 65535);
        chk_got("sat_edge", 2, 65534);
        read_chk("sat_rd", 4, 65535);

        // read-first collision on flow 9
        tick();
        put(9, 0, 20, 0);
        drain(3);
        tick();
        put(9, 0, 22, 0);
        tick();
        idle();
        tick();
        rd_en   = 1'b1;
        rd_addr = 4'd9;
        tick();
        @(negedge clk);
        chk("coll_old", 32'(rd_data), 20);
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        chk("coll_new", 32'(rd_data), 42);

        // reset with updates in flight
        tick();
        clear_got();
        put(1, 0, 5, 0);
        tick();
        put(2, 0, 6, 0);
        tick();
        put(8, 0, 7, 0);
        rst = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        init_count(1'b0);
        chk("rst_drop_n", got_ft.size(), 0);
        for (int i = 0; i < DEPTH; i++) read_chk("clear_rd", i, 0);

        clear_got();
        tick();
        put(3, 0, 1, 0);
        drain(4);
        chk_got("post_rst_ft", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wfq_ftime_table.md
Name: wfq_ftime_table

Overview:
- Parametrised successor to the WFQ per-flow finish-time RAM.
- Holds one finish time per flow and performs the WFQ update F_new = max(V, F_old) + (len << shift) as a pipelined read-modify-write with hazard forwarding.
- Clears itself in hardware after reset and offers an independent scheduler read port.
- Sits between packet classification (update side) and the WFQ min-finish-time scheduler (read side).

Parameters:
- ADDR_W, 13, flow-index width; table depth 2**ADDR_W.
- DATA_W, 16, finish-time / virtual-time width.
- LEN_W, 11, packet-length width.
- SH_W, 4, weight shift width (weight = 2**-shift as a length multiplier).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the table is being cleared.
- upd_valid  in  1  update request.
- upd_ready  out  1  update accepted when upd_valid && upd_ready.
- upd_flow  in  ADDR_W  flow index.
- upd_len  in  LEN_W  packet length.
- upd_shift  in  SH_W  weight shift.
- vtime  in  DATA_W  current virtual time, sampled on acceptance.
- res_valid  out  1  one-cycle pulse: updated finish time is available.
- res_flow  out  ADDR_W  flow index of the result.
- res_ftime  out  DATA_W  new finish time, equal to the value written to the table.
- rd_en  in  1  scheduler read strobe.
- rd_addr  in  ADDR_W  scheduler read index.
- rd_data  out  DATA_W  finish time, valid one cycle after rd_en.

Behaviour:
- Reset values: init_busy=1, upd_ready=0, res_valid=0, res_flow=0, res_ftime=0, rd_data=0. All pipeline valids are cleared and the FSM goes to INIT.
- FSM INIT:
  - Writes 0 to address cnt, with cnt running 0..2**ADDR_W-1, one write per cycle.
  - upd_ready=0. rd_data returns 0 regardless of array contents.
  - After the last address, transitions to RUN.
  - INIT lasts exactly 2**ADDR_W cycles after rst deasserts.
- FSM RUN: init_busy=0, upd_ready=1. There is no backpressure; throughput is one update per cycle.
- rst asserted in any state, including mid-INIT or with updates in flight:
  - In-flight updates are dropped; no res_valid is produced for them.
  - cnt restarts at 0 and clearing restarts from the beginning.
- Update pipeline, for an update accepted at cycle t:
  - S0 (t): register flow, len, shift and vtime; issue the synchronous array read.
  - S1 (t+1): take F_old from the array, or from the forwarded value (see hazard rule); compute F_new.
  - S2 (t+2): write F_new to the array; res_valid=1 with res_flow and res_ftime=F_new.
  - Latency is 2 cycles.
- Arithmetic:
  - inc = zero-extended len shifted left by shift.
  - sum = max(vtime, F_old) + inc, computed at DATA_W+1 bits or wider.
  - If inc or sum exceeds 2**DATA_W-1, F_new saturates to 2**DATA_W-1.
  - max is an unsigned compare; virtual-time wrap is the caller's responsibility.
- Hazard rule: results must match strictly sequential processing for any spacing of updates to the same flow.
  - Same flow updated back-to-back (gap 0): S1 uses the S2 F_new instead of the array output.
  - Gap 1: the array read collided with the write; S1 uses the value written in the previous cycle.
  - Gap 2 or more: the array value is correct.
- Scheduler read port:
  - Separate read port, implemented as a replicated array that shares the write.
  - rd_data registers array[rd_addr] one cycle after rd_en and holds its value when rd_en=0.
  - Read in the same cycle as a write to the same address returns the OLD value (read-first).
- Array contents are never altered except by INIT clearing or the S2 write.

Test Plan:
- Reset/INIT with ADDR_W=4: rst for 2 cycles, then release → init_busy high for exactly 16 cycles, upd_ready=0 throughout; a rd_en to addr 5 during INIT gives rd_data=0.
- Single update: flow 3, vtime=100, len=50, shift=1, table value 0 → res_valid at t+2 with res_flow=3, res_ftime=200; rd_addr=3 read afterwards gives 200.
- Back-to-back same flow: flow 7 updated at t and t+1, each with vtime=10, len=4, shift=0 → res_ftime 14 at t+2, then 18 at t+3. Repeat with gaps of 1 and 2 cycles → still 14 then 18.
- max selection: flow 2 holds 500; vtime=300, len=10, shift=0 → 510. Then vtime=900, len=10 → 910.
- Saturation with DATA_W=16: vtime=65530, len=2047, shift=4 → res_ftime=65535, and a later read of that flow gives 65535.
- Reset mid-operation: three updates in flight, then rst asserted → no res_valid for them; INIT reruns fully and every entry reads 0 afterwards.
- Read-first collision: rd_en to flow 9 in the same cycle as its S2 write of 42, with prior value 20 → rd_data=20; next-cycle read → 42.
